checker_scan: RTL and testbench

Memory-scan mode engine for the checker core. Sits directly downstream of `checker_ctlif`, beside `checker_dummy`, on the shared `cmode`/`cstart`/`caddr`/`cctrl`/`cend` control bus. When started in its mode it reads a block of 64-bit words from memory over a classic Wishbone-style read master port, accumulates a modular sum, and reports completion (`cend`), result (`csum`) and bus-timeout error (`cerr`) back to the control interface.

---
 rtl/checker_scan_pkg.sv | 15 +
 rtl/checker_scan_timer.sv | 28 ++
 rtl/checker_scan.sv | 130 +++++++++++++
 tb/tb_checker_scan.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/checker_scan_pkg.sv
// Shared constants and state encodings for the checker memory-scan engine.
package checker_scan_pkg;

  localparam logic [1:0]  CHECKER_MODE_SCAN = 2'd1;
  localparam logic [63:0] SCAN_WORD_BYTES   = 64'd8;
  localparam logic [63:0] SCAN_ADR_MASK     = ~64'h7;

  typedef enum logic [1:0] {
    CHECKER_SCAN_IDLE = 2'd0,
    CHECKER_SCAN_REQ  = 2'd1,
    CHECKER_SCAN_GAP  = 2'd2,
    CHECKER_SCAN_DONE = 2'd3
  } scan_state_e;

endpackage

// File: rtl/checker_scan_timer.sv
// Bus wait timer: counts cycles while enabled; expired marks the cycle whose
// closing edge would make the count reach TIMEOUT.
module checker_scan_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == 16'(TIMEOUT - 1));

endmodule

// File: rtl/checker_scan.sv
// Memory-scan checker engine: reads 1..256 aligned 64-bit words over a
// Wishbone-style read port and accumulates their sum modulo 2^64.
import checker_scan_pkg::*;

module checker_scan #(
  parameter logic [1:0]  mode    = CHECKER_MODE_SCAN,
  parameter int unsigned timeout = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [1:0]  cmode,
  input  logic        cstart,
  input  logic [63:0] caddr,
  input  logic [7:0]  cctrl,
  output logic        cend,
  output logic [63:0] csum,
  output logic        cerr,
  output logic        busy,
  output logic [63:0] mem_adr,
  output logic        mem_stb,
  input  logic        mem_ack,
  input  logic [63:0] mem_dat_r
);

  scan_state_e state_q, state_d;
  logic [63:0] adr_q, adr_d;
  logic [63:0] sum_q, sum_d;
  logic [7:0]  rem_q, rem_d;
  logic        stb_q, stb_d;
  logic        end_q, end_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        tmr_clear, tmr_en, tmr_expired;

  checker_scan_timer #(.TIMEOUT(timeout)) u_timer (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .clear_i   (tmr_clear),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    sum_d     = sum_q;
    rem_d     = rem_q;
    stb_d     = stb_q;
    end_d     = 1'b0;
    err_d     = err_q;
    busy_d    = busy_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      CHECKER_SCAN_IDLE: begin
        if (cstart && (cmode == mode)) begin
          adr_d     = caddr & SCAN_ADR_MASK;
          rem_d     = cctrl;
          sum_d     = '0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          stb_d     = 1'b1;
          tmr_clear = 1'b1;
          state_d   = CHECKER_SCAN_REQ;
        end
      end
      CHECKER_SCAN_REQ: begin
        // An ack on the expiry cycle still counts as a successful read.
        if (mem_ack) begin
          sum_d = sum_q + mem_dat_r;
          stb_d = 1'b0;
          if (rem_q == 8'd0) begin
            state_d = CHECKER_SCAN_DONE;
          end else begin
            rem_d   = rem_q - 8'd1;
            adr_d   = adr_q + SCAN_WORD_BYTES;
            state_d = CHECKER_SCAN_GAP;
          end
        end else if (tmr_expired) begin
          stb_d   = 1'b0;
          err_d   = 1'b1;
          state_d = CHECKER_SCAN_DONE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      CHECKER_SCAN_GAP: begin
        stb_d     = 1'b1;
        tmr_clear = 1'b1;
        state_d   = CHECKER_SCAN_REQ;
      end
      CHECKER_SCAN_DONE: begin
        end_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = CHECKER_SCAN_IDLE;
      end
      default: state_d = CHECKER_SCAN_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= CHECKER_SCAN_IDLE;
      adr_q   <= '0;
      sum_q   <= '0;
      rem_q   <= '0;
      stb_q   <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      sum_q   <= sum_d;
      rem_q   <= rem_d;
      stb_q   <= stb_d;
      end_q   <= end_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign mem_adr = adr_q;
  assign mem_stb = stb_q;
  assign cend    = end_q;
  assign csum    = sum_q;
  assign cerr    = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_checker_scan.sv
// Directed bench for checker_scan with a small behavioural memory slave.
module tb_checker_scan;

  logic        sys_clk, sys_rst;
  logic [1:0]  cmode;
  logic        cstart;
  logic [63:0] caddr;
  logic [7:0]  cctrl;
  logic        cend, cerr, busy, mem_stb, mem_ack;
  logic [63:0] csum, mem_adr, mem_dat_r;

  int checks = 0;
  int failures = 0;

  // 0: never ack, 1: zero-wait ack gated by stb, 2: ack held high always
  int ack_mode = 1;

  int n_cyc, stb_cyc, rises, busy_gap;
  bit done;
  logic [63:0] adr_log[$];

  checker_scan #(.mode(2'd1), .timeout(16)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .cmode     (cmode),
    .cstart    (cstart),
    .caddr     (caddr),
    .cctrl     (cctrl),
    .cend      (cend),
    .csum      (csum),
    .cerr      (cerr),
    .busy      (busy),
    .mem_adr   (mem_adr),
    .mem_stb   (mem_stb),
    .mem_ack   (mem_ack),
    .mem_dat_r (mem_dat_r)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [63:0] data_for(input logic [63:0] a);
    case (a)
      64'h1000:               return 64'h1234;
      64'hFFFF_FFFF_FFFF_FFF8: return 64'hFFFF_FFFF_FFFF_FFFF;
      64'h0:                  return 64'd2;
      64'h8:                  return 64'd5;
      default:                return a;
    endcase
  endfunction

  always_comb begin
    mem_dat_r = data_for(mem_adr);
    case (ack_mode)
      1:       mem_ack = mem_stb;
      2:       mem_ack = 1'b1;
      default: mem_ack = 1'b0;
    endcase
  end

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [1:0] m, input logic [63:0] a, input logic [7:0] c);
    cmode  = m;
    caddr  = a;
    cctrl  = c;
    cstart = 1'b1;
    tick;
    cstart = 1'b0;
  endtask

  // Called just after the start edge; observes every cycle until cend.
  task automatic run_scan(input int budget, input int inject_at);
    bit prev;
    n_cyc = 0; stb_cyc = 0; rises = 0; busy_gap = 0; done = 0; prev = 0;
    adr_log.delete();
    for (int i = 0; i < budget; i++) begin
      if (cend) begin
        done = 1;
        break;
      end
      if (mem_stb) stb_cyc++;
      if (mem_stb && !prev) rises++;
      prev = mem_stb;
      if (busy && !mem_stb) busy_gap++;
      if (mem_stb && mem_ack) adr_log.push_back(mem_adr);
      if (i == inject_at) begin
        cmode = 2'd1; caddr = 64'h4000; cctrl = 8'd0; cstart = 1'b1;
      end else begin
        cstart = 1'b0;
      end
      tick;
      n_cyc++;
    end
    cstart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cend_seen;
    sys_rst = 1'b1; cmode = 2'd0; cstart = 1'b0; caddr = '0; cctrl = '0;
    tick; tick; tick;
    chk("rst_stb",  mem_stb, 1'b0);
    chk("rst_adr",  mem_adr, 64'h0);
    chk("rst_cend", cend,    1'b0);
    chk("rst_busy", busy,    1'b0);
    chk("rst_cerr", cerr,    1'b0);
    chk("rst_csum", csum,    64'h0);
    sys_rst = 1'b0;
    tick;

    // single word, unaligned start address
    ack_mode = 1;
    start(2'd1, 64'h1005, 8'd0);
    chk("t1_busy", busy, 1'b1);
    run_scan(50, -1);
    chk("t1_done",  done,    1'b1);
    chk("t1_cyc",   n_cyc,   64'd2);
    chk("t1_adr",   adr_log.size() > 0 ? adr_log[0] : 64'hDEAD, 64'h1000);
    chk("t1_stb",   stb_cyc, 64'd1);
    chk("t1_csum",  csum,    64'h1234);
    chk("t1_cerr",  cerr,    1'b0);
    chk("t1_busy0", busy,    1'b0);
    tick;
    chk("t1_pulse", cend,    1'b0);
    chk("t1_hold",  csum,    64'h1234);

    // address wrap, modular sum, ack held high through gaps
    ack_mode = 2;
    start(2'd1, 64'hFFFF_FFFF_FFFF_FFF8, 8'd2);
    run_scan(50, -1);
    chk("t2_done",  done,     1'b1);
    chk("t2_cyc",   n_cyc,    64'd6);
    chk("t2_nadr",  adr_log.size(), 64'd3);
    chk("t2_adr0",  adr_log.size() > 0 ? adr_log[0] : 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("t2_adr1",  adr_log.size() > 1 ? adr_log[1] : 64'hDEAD, 64'h0);
    chk("t2_adr2",  adr_log.size() > 2 ? adr_log[2] : 64'hDEAD, 64'h8);
    chk("t2_rises", rises,    64'd3);
    chk("t2_lowbusy", busy_gap, 64'd3);
    chk("t2_csum",  csum,     64'd6);

    // maximum length: 256 words from 0x100, data equals address
    ack_mode = 1;
    start(2'd1, 64'h100, 8'd255);
    run_scan(600, -1);
    chk("t3_done", done,    1'b1);
    chk("t3_cyc",  n_cyc,   64'd512);
    chk("t3_stb",  stb_cyc, 64'd256);
    chk("t3_last", adr_log.size() > 255 ? adr_log[255] : 64'hDEAD, 64'h8F8);
    chk("t3_csum", csum,    64'h4FC00);
    chk("t3_cerr", cerr,    1'b0);

    // slave never acks: 16-cycle timeout
    ack_mode = 0;
    start(2'd1, 64'h2000, 8'd3);
    run_scan(50, -1);
    chk("t4_done", done,    1'b1);
    chk("t4_stb",  stb_cyc, 64'd16);
    chk("t4_cyc",  n_cyc,   64'd17);
    chk("t4_cerr", cerr,    1'b1);
    chk("t4_csum", csum,    64'h0);
    tick;
    chk("t4_hold", cerr,    1'b1);

    // wrong mode is ignored
    ack_mode = 1;
    start(2'd0, 64'h3000, 8'd0);
    chk("t5_nostb",  mem_stb, 1'b0);
    chk("t5_nobusy", busy,    1'b0);
    tick;
    chk("t5_nostb2", mem_stb, 1'b0);
    chk("t5_cerr",   cerr,    1'b1);

    // restart while busy is ignored
    start(2'd1, 64'h200, 8'd3);
    run_scan(50, 3);
    chk("t6_done",  done,  1'b1);
    chk("t6_cyc",   n_cyc, 64'd8);
    chk("t6_nadr",  adr_log.size(), 64'd4);
    chk("t6_adr3",  adr_log.size() > 3 ? adr_log[3] : 64'hDEAD, 64'h218);
    chk("t6_csum",  csum,  64'h830);
    chk("t6_cerr",  cerr,  1'b0);
    tick;
    chk("t6_idle",  mem_stb, 1'b0);

    // reset during the third request of a 4-word scan
    start(2'd1, 64'h300, 8'd3);
    tick; tick; tick; tick;
    chk("t7_req3_stb", mem_stb, 1'b1);
    chk("t7_req3_adr", mem_adr, 64'h310);
    chk("t7_req3_sum", csum,    64'h608);
    sys_rst = 1'b1;
    tick;
    sys_rst = 1'b0;
    chk("t7_rst_stb",  mem_stb, 1'b0);
    chk("t7_rst_adr",  mem_adr, 64'h0);
    chk("t7_rst_busy", busy,    1'b0);
    chk("t7_rst_csum", csum,    64'h0);
    cend_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (cend || mem_stb) cend_seen++;
      tick;
    end
    chk("t7_quiet", cend_seen, 64'd0);
    start(2'd1, 64'h500, 8'd1);
    run_scan(50, -1);
    chk("t7_done", done,  1'b1);
    chk("t7_cyc",  n_cyc, 64'd4);
    chk("t7_csum", csum,  64'hA08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
